// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for rr_arbiter and its priority encoder.
// Build option: RR_ARBITER_LOCK_EN (see rr_arbiter.sv).
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    localparam string TYPE_PRIORITY    = "PRIORITY";
    localparam string TYPE_ROUND_ROBIN = "ROUND_ROBIN";
    localparam string LSB_PRIO_HIGH    = "HIGH";
    localparam string LSB_PRIO_LOW     = "LOW";

    // Pointer value that makes the first round-robin pick equal the fixed-priority pick.
    function automatic int unsigned ptr_reset_value(input int unsigned ports, input bit lsb_high);
        return lsb_high ? ports - 1 : 0;
    endfunction

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// Combinational priority encoder: index of the winning set bit per LSB_PRIORITY.
// Build option: none.
module priority_encoder
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter string       LSB_PRIORITY = "HIGH"
) (
    input  logic [WIDTH-1:0]         input_unencoded,
    output logic                     output_valid,
    output logic [$clog2(WIDTH)-1:0] output_encoded
);

    localparam int unsigned ENC_W    = $clog2(WIDTH);
    localparam bit          LSB_HIGH = (LSB_PRIORITY == LSB_PRIO_HIGH);

    assign output_valid = |input_unencoded;

    // Later assignments win, so scan towards the preferred end.
    always_comb begin
        output_encoded = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH) begin
                if (input_unencoded[WIDTH-1-i]) output_encoded = ENC_W'(WIDTH - 1 - i);
            end else if (input_unencoded[i]) begin
                output_encoded = ENC_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin, grant held until release.
// Build option: RR_ARBITER_LOCK_EN -- grant released by acknowledge only.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned PORTS        = 4,
    parameter string       TYPE         = "ROUND_ROBIN",
    parameter string       LSB_PRIORITY = "HIGH"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int unsigned W        = $clog2(PORTS);
    localparam bit          IS_RR    = (TYPE == TYPE_ROUND_ROBIN);
    localparam bit          LSB_HIGH = (LSB_PRIORITY == LSB_PRIO_HIGH);
    localparam logic [W-1:0] PTR_RST = W'(ptr_reset_value(PORTS, LSB_HIGH));

    arb_state_e       state_q;
    logic [PORTS-1:0] grant_q;
    logic             grant_valid_q;
    logic [W-1:0]     grant_encoded_q;
    logic [W-1:0]     ptr_q;

    logic [PORTS-1:0] req_masked;
    logic [31:0]      ptr_ext;
    logic             unm_valid, msk_valid;
    logic [W-1:0]     unm_enc, msk_enc;
    logic [W-1:0]     win_enc;
    logic [PORTS-1:0] win_onehot;
    logic             rel;

    assign ptr_ext = 32'(ptr_q);

    // Masked vector holds only requesters after ptr in round-robin order.
    always_comb begin
        req_masked = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (LSB_HIGH ? (i > ptr_ext) : (i < ptr_ext)) req_masked[i] = request[i];
        end
    end

    priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_pe_unmasked (
        .input_unencoded (request),
        .output_valid    (unm_valid),
        .output_encoded  (unm_enc)
    );

    priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_pe_masked (
        .input_unencoded (req_masked),
        .output_valid    (msk_valid),
        .output_encoded  (msk_enc)
    );

    assign win_enc    = (IS_RR && msk_valid) ? msk_enc : unm_enc;
    assign win_onehot = PORTS'(1) << win_enc;

`ifdef RR_ARBITER_LOCK_EN
    assign rel = |(acknowledge & grant_q);
`else
    assign rel = |(acknowledge & grant_q) | ~|(request & grant_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            grant_encoded_q <= '0;
            ptr_q           <= PTR_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (unm_valid) begin
                        state_q         <= GRANTED;
                        grant_q         <= win_onehot;
                        grant_valid_q   <= 1'b1;
                        grant_encoded_q <= win_enc;
                        ptr_q           <= win_enc;
                    end
                end
                GRANTED: begin
                    if (rel) begin
                        if (unm_valid) begin
                            grant_q         <= win_onehot;
                            grant_valid_q   <= 1'b1;
                            grant_encoded_q <= win_enc;
                            ptr_q           <= win_enc;
                        end else begin
                            state_q         <= IDLE;
                            grant_q         <= '0;
                            grant_valid_q   <= 1'b0;
                            grant_encoded_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = grant_valid_q;
    assign grant_encoded = grant_encoded_q;

endmodule
